// File: rtl/ola_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ola_frame_ctrl
//  Purpose  : Frame sequencer in front of the overlap-add stage. Forwards
//             IFFT samples frame by frame with zero latency. Regenerates
//             tlast from a local sample count. Drives last_frame to the
//             overlap-add block. Watches the overlap-add output handshake
//             until the final tail has been flushed, then pulses done.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset            sole clock (rising edge), synchronous active-high
//    start, num_frames     one-cycle run request, frame count sampled on start
//    busy, done            run in progress / one-cycle end-of-run pulse
//    frame_idx             index of the frame currently being forwarded
//    last_frame            to overlap-add: final frame forwarding and drain
//    s_axis_*              IFFT sample stream in
//    m_axis_*              sample stream out to overlap-add
//    mon_tvalid/mon_tready observed overlap-add output handshake
//    err                   sticky framing error
//  Build option
//    OLA_CTRL_ERRCHK_EN    when defined, err flags upstream tlast that
//                          disagrees with the local frame position; when
//                          undefined, err is tied low and s_axis_tlast is
//                          ignored.
// ============================================================================
module ola_frame_ctrl #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FRAME_LEN    = 4096,
    parameter int HOP_LEN      = 1024,
    parameter int FRAME_CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [FRAME_CNT_W-1:0]    num_frames,
    output logic                      busy,
    output logic                      done,
    output logic [FRAME_CNT_W-1:0]    frame_idx,
    output logic                      last_frame,
    input  logic                      s_axis_tvalid,
    input  logic [SAMPLE_WIDTH-1:0]   s_axis_tdata,
    input  logic [SAMPLE_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_tready,
    output logic                      m_axis_tvalid,
    output logic [SAMPLE_WIDTH-1:0]   m_axis_tdata,
    output logic [SAMPLE_WIDTH/8-1:0] m_axis_tkeep,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    input  logic                      mon_tvalid,
    input  logic                      mon_tready,
    output logic                      err
);

    localparam int c_SAMP_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    // Output count must hold num_frames*HOP_LEN plus the overlap tail.
    localparam int c_OUT_W  = FRAME_CNT_W + 13;

    localparam logic [c_SAMP_W-1:0] c_SAMP_LAST = c_SAMP_W'(FRAME_LEN - 1);
    localparam logic [c_OUT_W-1:0]  c_HOP       = c_OUT_W'(HOP_LEN);
    localparam logic [c_OUT_W-1:0]  c_OVERLAP   = c_OUT_W'(FRAME_LEN - HOP_LEN);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [FRAME_CNT_W-1:0] r_nf;
    logic [FRAME_CNT_W-1:0] r_frame_idx;
    logic [c_SAMP_W-1:0]    r_samp_cnt;
    logic [c_OUT_W-1:0]     r_out_cnt;
    logic [c_OUT_W-1:0]     r_out_target;
    logic                   r_last_frame;

    logic w_run;
    logic w_beat;
    logic w_samp_last;
    logic w_frame_last;
    logic w_start_ok;
    logic w_out_done;
    logic w_mon_beat;

    assign w_run        = (r_state == c_ST_RUN);
    assign w_beat       = w_run & s_axis_tvalid & m_axis_tready;
    assign w_samp_last  = (r_samp_cnt == c_SAMP_LAST);
    assign w_frame_last = (r_frame_idx == (r_nf - FRAME_CNT_W'(1)));
    assign w_start_ok   = (r_state == c_ST_IDLE) & start;
    assign w_out_done   = (r_out_cnt == r_out_target);
    // The output count saturates at its target so that surplus monitored
    // beats (in RUN or DRAIN) never push it past the exit condition.
    assign w_mon_beat   = mon_tvalid & mon_tready & ~w_out_done &
                          ((r_state == c_ST_RUN) | (r_state == c_ST_DRAIN));

    // ------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        busy          = 1'b0;
        done          = 1'b0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_next = (num_frames == '0) ? c_ST_DONE : c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                busy          = 1'b1;
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                if (w_beat && w_samp_last && w_frame_last) begin
                    w_state_next = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                busy = 1'b1;
                if (w_out_done) begin
                    w_state_next = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_nf         <= '0;
            r_frame_idx  <= '0;
            r_samp_cnt   <= '0;
            r_out_cnt    <= '0;
            r_out_target <= '0;
            r_last_frame <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_start_ok) begin
                r_nf         <= num_frames;
                r_out_target <= c_OUT_W'(num_frames) * c_HOP + c_OVERLAP;
                r_frame_idx  <= '0;
                r_samp_cnt   <= '0;
                r_out_cnt    <= '0;
            end else begin
                if (w_beat) begin
                    if (w_samp_last) begin
                        r_samp_cnt  <= '0;
                        r_frame_idx <= r_frame_idx + FRAME_CNT_W'(1);
                    end else begin
                        r_samp_cnt <= r_samp_cnt + c_SAMP_W'(1);
                    end
                end
                if (w_mon_beat) begin
                    r_out_cnt <= r_out_cnt + c_OUT_W'(1);
                end
            end

            // Cleared on the way into DONE so it is already low there.
            if (w_state_next == c_ST_DONE) begin
                r_last_frame <= 1'b0;
            end else if (w_run && w_frame_last) begin
                r_last_frame <= 1'b1;
            end
        end
    end

    assign frame_idx    = r_frame_idx;
    assign last_frame   = r_last_frame;
    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tkeep = s_axis_tkeep;
    // Upstream tlast is never forwarded; the local count defines framing.
    assign m_axis_tlast = w_samp_last;

    // ------------------------------------------------------------------
    // Framing error check
    // ------------------------------------------------------------------
`ifdef OLA_CTRL_ERRCHK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_start_ok) begin
            r_err <= 1'b0;
        end else if (w_beat && (s_axis_tlast != w_samp_last)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_tlast;

    assign w_unused_tlast = s_axis_tlast;
    assign err            = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ola_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ola_frame_ctrl
//  Purpose  : Self-checking bench for ola_frame_ctrl. A run-level model
//             (beat totals, frame = beats / FRAME_LEN, saturating output
//             tally) predicts every output each cycle. Directed scenarios add
//             literal expectations on beat counts, tlast positions and
//             done timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ola_frame_ctrl;

    localparam int SW  = 16;
    localparam int FL  = 4096;
    localparam int HOP = 1024;
    localparam int FW  = 16;

    localparam int ST_IDLE  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_DRAIN = 2;
    localparam int ST_DONE  = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [FW-1:0]   num_frames;
    logic            busy;
    logic            done;
    logic [FW-1:0]   frame_idx;
    logic            last_frame;
    logic            s_axis_tvalid;
    logic [SW-1:0]   s_axis_tdata;
    logic [SW/8-1:0] s_axis_tkeep;
    logic            s_axis_tlast;
    logic            s_axis_tready;
    logic            m_axis_tvalid;
    logic [SW-1:0]   m_axis_tdata;
    logic [SW/8-1:0] m_axis_tkeep;
    logic            m_axis_tlast;
    logic            m_axis_tready;
    logic            mon_tvalid;
    logic            mon_tready;
    logic            err;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int   md_st = ST_IDLE;
    int   md_beats = 0;
    int   md_nf = 0;
    int   md_target = 0;
    int   md_outc = 0;
    logic md_lastf = 1'b0;
    logic md_err = 1'b0;

    // run statistics observed from the DUT
    int   cyc = 0;
    int   m_beats = 0;
    int   mon_tally = 0;
    int   tgt_lit = 0;
    int   tgt_cyc = -1;
    int   done_cyc = -1;
    int   start_cyc = -1;
    int   last_beat_cyc = -1;
    int   mtv_seen = 0;
    int   lf_rise_frame = -1;
    logic done_seen = 1'b0;
    logic lf_prev = 1'b0;
    int   tlast_q[$];

    // stimulus knobs
    int p_valid = 100;
    int p_ready = 100;
    int p_mon   = 0;
    int p_monr  = 100;
    int src_idx = 0;
    int inject_at = -1;

    ola_frame_ctrl #(
        .SAMPLE_WIDTH (SW),
        .FRAME_LEN    (FL),
        .HOP_LEN      (HOP),
        .FRAME_CNT_W  (FW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .num_frames    (num_frames),
        .busy          (busy),
        .done          (done),
        .frame_idx     (frame_idx),
        .last_frame    (last_frame),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .mon_tvalid    (mon_tvalid),
        .mon_tready    (mon_tready),
        .err           (err)
    );

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] data_of(input int i);
        return SW'(i * 37 + 5);
    endfunction

    function automatic logic [SW/8-1:0] keep_of(input int i);
        return (i % 3 == 0) ? 2'b01 : 2'b11;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Compare process: checks every output against the model on the
    // falling edge, then advances the model with this cycle's inputs.
    // ------------------------------------------------------------------
    initial begin : cmp
        logic [63:0] ev;
        logic [63:0] av;
        logic [FW-1:0] e_frame;
        logic e_busy, e_done, e_mtv, e_str, e_mtl, monhs;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            e_busy  = (md_st != ST_IDLE);
            e_done  = (md_st == ST_DONE);
            e_frame = FW'(md_beats / FL);
            e_mtv   = (md_st == ST_RUN) && s_axis_tvalid;
            e_str   = (md_st == ST_RUN) && m_axis_tready;
            e_mtl   = ((md_beats % FL) == FL - 1);
            ev = {23'd0, e_busy, e_done, e_frame, md_lastf, e_mtv, e_str, e_mtl,
                  md_err, s_axis_tdata, s_axis_tkeep};
            av = {23'd0, busy, done, frame_idx, last_frame, m_axis_tvalid,
                  s_axis_tready, m_axis_tlast, err, m_axis_tdata, m_axis_tkeep};
            check("outputs", av, ev);

            // statistics
            if (m_axis_tvalid === 1'b1) mtv_seen++;
            if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
                check("order", {48'd0, m_axis_tdata}, {48'd0, data_of(m_beats)});
                if (m_axis_tlast === 1'b1) tlast_q.push_back(m_beats);
                last_beat_cyc = cyc;
                m_beats++;
            end
            monhs = mon_tvalid && mon_tready && (md_st == ST_RUN || md_st == ST_DRAIN);
            if (monhs) begin
                mon_tally++;
                if (mon_tally == tgt_lit) tgt_cyc = cyc;
            end
            if (done === 1'b1) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
            if (last_frame === 1'b1 && !lf_prev) lf_rise_frame = frame_idx;
            lf_prev = last_frame;

            // model step
            if (reset) begin
                md_st = ST_IDLE; md_beats = 0; md_outc = 0;
                md_lastf = 1'b0; md_err = 1'b0;
            end else begin
                case (md_st)
                    ST_IDLE: if (start) begin
                        md_nf     = int'(num_frames);
                        md_target = md_nf * HOP + (FL - HOP);
                        md_beats  = 0;
                        md_outc   = 0;
                        md_err    = 1'b0;
                        md_st     = (md_nf == 0) ? ST_DONE : ST_RUN;
                        m_beats = 0; mon_tally = 0; tgt_cyc = -1; mtv_seen = 0;
                        done_seen = 1'b0; lf_rise_frame = -1; start_cyc = cyc;
                        tlast_q.delete();
                    end
                    ST_RUN: begin
                        if (monhs && md_outc < md_target) md_outc++;
                        if (md_beats / FL == md_nf - 1) md_lastf = 1'b1;
                        if (s_axis_tvalid && m_axis_tready) begin
`ifdef OLA_CTRL_ERRCHK_EN
                            if (s_axis_tlast != e_mtl) md_err = 1'b1;
`endif
                            md_beats++;
                            if (md_beats == md_nf * FL) md_st = ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (md_outc == md_target) begin
                            md_st = ST_DONE;
                            md_lastf = 1'b0;
                        end else if (monhs) begin
                            md_outc++;
                        end
                    end
                    default: md_st = ST_IDLE;
                endcase
            end
        end
    end

    // One clock of stimulus: inputs change 1 time unit after the rising edge.
    task automatic tick();
        logic hs;
        @(negedge clk);
        hs = s_axis_tvalid && s_axis_tready && !reset;
        @(posedge clk);
        #1;
        if (hs) src_idx++;
        if (!s_axis_tvalid || hs) s_axis_tvalid = ($urandom_range(99) < p_valid);
        s_axis_tdata  = data_of(src_idx);
        s_axis_tkeep  = keep_of(src_idx);
        s_axis_tlast  = ((src_idx % FL) == FL - 1) != (src_idx == inject_at);
        m_axis_tready = ($urandom_range(99) < p_ready);
        mon_tvalid    = ($urandom_range(99) < p_mon);
        mon_tready    = ($urandom_range(99) < p_monr);
    endtask

    task automatic pulse_start(input int n);
        src_idx    = 0;
        start      = 1'b1;
        num_frames = FW'(n);
        tick();
        start      = 1'b0;
        num_frames = FW'($urandom);
    endtask

    task automatic run_until_done(input int budget, input string name);
        int n = 0;
        while (!done_seen && n < budget) begin
            tick();
            n++;
        end
        if (!done_seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: done not seen within %0d cycles", name, budget);
        end
        repeat (2) tick();
    endtask

    task automatic wait_src(input int target, input int budget, input string name);
        int n = 0;
        while (src_idx < target && n < budget) begin
            tick();
            n++;
        end
        if (src_idx < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: only %0d beats accepted, wanted %0d", name, src_idx, target);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; num_frames = '0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b0; mon_tvalid = 1'b0; mon_tready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset_flags", {busy, done, last_frame, m_axis_tvalid, m_axis_tlast, s_axis_tready, err}, 7'b0);
        check("reset_frame_idx", frame_idx, 0);

        // 1: three frames, continuous stream, monitor 40% so the tail drains
        p_valid = 100; p_ready = 100; p_mon = 40; p_monr = 100; tgt_lit = 6144;
        pulse_start(3);
        run_until_done(40000, "t1_done");
        check("t1_beats", m_beats, 12288);
        check("t1_tlast_n", tlast_q.size(), 3);
        for (int k = 0; k < tlast_q.size() && k < 3; k++)
            check("t1_tlast_pos", tlast_q[k], (k + 1) * FL - 1);
        check("t1_lastf_rise_idx", lf_rise_frame, 2);
        // 6144th monitored beat at cycle j: count visible at j+1, done at j+2
        check("t1_done_lat", done_cyc - tgt_cyc, 2);

        // 2: two frames with stalls; output target met while still in RUN
        p_valid = 80; p_ready = 80; p_mon = 50; p_monr = 100; tgt_lit = 5120;
        pulse_start(2);
        run_until_done(40000, "t2_done");
        check("t2_beats", m_beats, 8192);
        check("t2_tlast_n", tlast_q.size(), 2);
        check("t2_target_hit", (tgt_cyc >= 0) && (tgt_cyc < last_beat_cyc), 1);
        // DRAIN entered after the final beat, exits on the following cycle
        check("t2_done_lat", done_cyc - last_beat_cyc, 2);

        // 3: zero frames. start is sampled on the first edge, done is high
        // in the next cycle and is seen at the second edge.
        p_valid = 100; p_ready = 100; p_mon = 50;
        pulse_start(0);
        run_until_done(10, "t3_done");
        check("t3_done_lat", done_cyc - start_cyc, 1);
        check("t3_no_valid", mtv_seen, 0);

        // 4: second start mid-run is ignored
        tgt_lit = 4096;
        pulse_start(1);
        repeat (1000) tick();
        start = 1'b1; num_frames = 16'd5;
        tick();
        start = 1'b0;
        run_until_done(20000, "t4_done");
        check("t4_beats", m_beats, 4096);
        check("t4_frame_idx", frame_idx, 1);
        check("t4_tlast_n", tlast_q.size(), 1);

        // 5: reset at beat 2000 of frame 1, then a one-frame run
        p_mon = 30;
        pulse_start(2);
        wait_src(FL + 2000, 20000, "t5_reach");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_reset_flags", {busy, done, last_frame, m_axis_tvalid, m_axis_tlast, s_axis_tready, err}, 7'b0);
        check("t5_reset_frame_idx", frame_idx, 0);
        check("t5_no_done", done_seen, 0);
        p_mon = 50; tgt_lit = 4096;
        pulse_start(1);
        run_until_done(20000, "t5_done");
        check("t5_beats", m_beats, 4096);
        check("t5_done_lat", done_cyc - tgt_cyc, 2);

`ifdef OLA_CTRL_ERRCHK_EN
        // 6: injected tlast at beat 100 sets err; the next start clears it
        p_mon = 60; inject_at = 100;
        pulse_start(1);
        wait_src(102, 2000, "t6_reach");
        check("t6_err_set", err, 1);
        run_until_done(20000, "t6_done");
        inject_at = -1;
        check("t6_err_sticky", err, 1);
        check("t6_tlast_n", tlast_q.size(), 1);
        if (tlast_q.size() > 0) check("t6_tlast_pos", tlast_q[0], FL - 1);
        pulse_start(0);
        check("t6_err_clear", err, 0);
        run_until_done(10, "t6_done0");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
